// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons sharing one configuration.
// Each neuron keeps its own membrane potential and refractory counter and
// moves between INTEGRATE and REFRACTORY. Outputs are registered; v_out
// shows the selected neuron's potential one cycle after it is selected.
module lif_neuron_array #(
  parameter int N_NEURONS = 4,
  parameter int V_WIDTH   = 8,
  parameter int IN_WIDTH  = 8,
  localparam int SEL_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          step,
  input  logic [N_NEURONS*IN_WIDTH-1:0] in_data,
  input  logic                          cfg_we,
  input  logic [1:0]                    cfg_addr,
  input  logic [V_WIDTH-1:0]            cfg_wdata,
  input  logic [SEL_W-1:0]              v_sel,
  output logic [N_NEURONS-1:0]          spike,
  output logic [V_WIDTH-1:0]            v_out,
  output logic                          spike_any
);

  typedef enum logic {
    INTEGRATE  = 1'b0,
    REFRACTORY = 1'b1
  } nstate_t;

  localparam logic [V_WIDTH-1:0] THRESH_RST = {1'b1, {(V_WIDTH-1){1'b0}}};

  // Shared configuration
  logic [V_WIDTH-1:0] thresh_q;
  logic [3:0]         shift_a_q;
  logic [3:0]         shift_b_q;
  logic [7:0]         refrac_q;
  logic               rst_mode_q;

  // Per-neuron state and its next-state values
  nstate_t            st_q  [N_NEURONS];
  nstate_t            st_d  [N_NEURONS];
  logic [7:0]         rc_q  [N_NEURONS];
  logic [7:0]         rc_d  [N_NEURONS];
  logic [V_WIDTH-1:0] v_q   [N_NEURONS];
  logic [V_WIDTH-1:0] v_d   [N_NEURONS];
  logic [V_WIDTH-1:0] vn    [N_NEURONS];
  logic [N_NEURONS-1:0] spike_d;

  logic do_step;
  logic do_clear;

  // Leak term: sum of the two enabled shifts, never larger than V itself.
  function automatic logic [V_WIDTH-1:0] leak_of(input logic [V_WIDTH-1:0] v,
                                                 input logic [3:0] sa,
                                                 input logic [3:0] sb);
    logic [V_WIDTH:0] l;
    l = '0;
    if (sa != 4'd0) l = l + {1'b0, v >> sa};
    if (sb != 4'd0) l = l + {1'b0, v >> sb};
    if (l > {1'b0, v}) l = {1'b0, v};
    return l[V_WIDTH-1:0];
  endfunction

  // Clamp a one-bit-wider sum to the largest representable potential.
  function automatic logic [V_WIDTH-1:0] sat_v(input logic [V_WIDTH:0] x);
    return x[V_WIDTH] ? {V_WIDTH{1'b1}} : x[V_WIDTH-1:0];
  endfunction

  // One integration step: V - leak + I with saturation.
  function automatic logic [V_WIDTH-1:0] integrate(input logic [V_WIDTH-1:0] v,
                                                   input logic [IN_WIDTH-1:0] cur,
                                                   input logic [3:0] sa,
                                                   input logic [3:0] sb);
    logic [V_WIDTH:0] sum;
    sum = {1'b0, v} - {1'b0, leak_of(v, sa, sb)} + (V_WIDTH+1)'(cur);
    return sat_v(sum);
  endfunction

  assign do_step  = ena & step;
  assign do_clear = ena & cfg_we & (cfg_addr == 2'd3) & cfg_wdata[1];

  // Next-state logic for every neuron; CLEAR wins over a simultaneous step.
  always_comb begin
    spike_d = '0;
    for (int k = 0; k < N_NEURONS; k++) begin
      st_d[k] = st_q[k];
      rc_d[k] = rc_q[k];
      v_d[k]  = v_q[k];
      vn[k]   = integrate(v_q[k], in_data[k*IN_WIDTH +: IN_WIDTH], shift_a_q, shift_b_q);
      if (do_clear) begin
        st_d[k] = INTEGRATE;
        rc_d[k] = '0;
        v_d[k]  = '0;
      end else if (do_step) begin
        case (st_q[k])
          REFRACTORY: begin
            rc_d[k] = rc_q[k] - 8'd1;
            if (rc_q[k] <= 8'd1) st_d[k] = INTEGRATE;
          end
          default: begin
            if ((thresh_q != '0) && (vn[k] >= thresh_q)) begin
              spike_d[k] = 1'b1;
              v_d[k]     = rst_mode_q ? (vn[k] - thresh_q) : '0;
              rc_d[k]    = refrac_q;
              st_d[k]    = (refrac_q != 8'd0) ? REFRACTORY : INTEGRATE;
            end else begin
              v_d[k] = vn[k];
            end
          end
        endcase
      end
    end
  end

  // Neuron state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        st_q[k] <= INTEGRATE;
        rc_q[k] <= '0;
        v_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < N_NEURONS; k++) begin
        st_q[k] <= st_d[k];
        rc_q[k] <= rc_d[k];
        v_q[k]  <= v_d[k];
      end
    end
  end

  // Configuration writes; a write alongside a step only affects later steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh_q   <= THRESH_RST;
      shift_a_q  <= 4'd2;
      shift_b_q  <= 4'd4;
      refrac_q   <= 8'd2;
      rst_mode_q <= 1'b0;
    end else if (ena && cfg_we) begin
      case (cfg_addr)
        2'd0: thresh_q <= cfg_wdata;
        2'd1: begin
          shift_a_q <= cfg_wdata[3:0];
          shift_b_q <= cfg_wdata[7:4];
        end
        2'd2: refrac_q   <= cfg_wdata[7:0];
        default: rst_mode_q <= cfg_wdata[0];
      endcase
    end
  end

  // Registered outputs: one-cycle spike pulses and the potential read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike     <= '0;
      spike_any <= 1'b0;
      v_out     <= '0;
    end else begin
      spike     <= spike_d;
      spike_any <= |spike_d;
      v_out     <= (int'(v_sel) < N_NEURONS) ? v_q[v_sel] : '0;
    end
  end

endmodule
